// File: rtl/gcd_accel_bank.sv
// GCD coprocessor bank: per-channel operand/result register sets
// sharing one subtract-based GCD engine under round-robin arbitration.
module gcd_accel_bank #(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 4,
  parameter logic [15:0] BASE_ADDR = 16'hF8
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STORE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a1 [CHANNELS];
  logic [WIDTH-1:0] r_a2 [CHANNELS];
  logic [WIDTH-1:0] r_w  [CHANNELS];

  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_busy;
  logic [CHANNELS-1:0] r_done;
  logic [CHANNELS-1:0] r_err;
  logic [CHANNELS-1:0] r_rej;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_gnt;
  logic [2:0]       r_rr;

  logic [31:0] r_done_cnt;
  logic [31:0] r_start_cnt;
  logic [31:0] r_gpio;
  logic [31:0] r_sdata;
  logic [31:0] r_rd_data;
  logic        r_rd_v;

  logic [15:0] w_off;
  logic        w_in_rng;
  logic [3:0]  w_idx;
  logic [1:0]  w_reg;
  logic [2:0]  w_ch;
  logic        w_is_ch;
  logic        w_is_g;
  logic [31:0] w_rdata;
  logic        w_wr_op;
  logic        w_rej;
  logic        w_fin;
  logic        w_any;
  logic [2:0]  w_gnt;

  assign w_off    = saddress - BASE_ADDR;
  assign w_in_rng = (saddress >= BASE_ADDR)
                 && (w_off[15:4] <= 12'(CHANNELS))
                 && (w_off[1:0] == 2'b00);
  assign w_idx    = w_off[7:4];
  assign w_reg    = w_off[3:2];
  assign w_ch     = w_idx[2:0];
  assign w_is_ch  = w_in_rng && (w_idx < 4'(CHANNELS));
  assign w_is_g   = w_in_rng && (w_idx == 4'(CHANNELS));

  assign w_wr_op = swr && w_is_ch && !w_reg[1];
  assign w_rej   = w_wr_op && r_busy[w_ch];

  assign w_fin = (r_a == '0) || (r_b == '0) || (r_a == r_b);

  // first pending channel at or after the round-robin pointer
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      int j;
      j = (int'(r_rr) + i) % CHANNELS;
      if (!w_any && r_pend[j]) begin
        w_any = 1'b1;
        w_gnt = 3'(j);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ch) begin
      unique case (w_reg)
        2'd0: w_rdata = 32'(r_a1[w_ch]);
        2'd1: w_rdata = 32'(r_a2[w_ch]);
        2'd2: w_rdata = 32'(r_w[w_ch]);
        2'd3: w_rdata = {28'd0, r_rej[w_ch], r_err[w_ch],
                         r_done[w_ch], r_busy[w_ch]};
      endcase
    end else if (w_is_g) begin
      unique case (w_reg)
        2'd0:    w_rdata = r_done_cnt;
        2'd1:    w_rdata = r_start_cnt;
        2'd2:    w_rdata = r_gpio;
        default: w_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_RUN;
      S_RUN:   if (w_fin) w_next = S_STORE;
      S_STORE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_a1[i] <= '0;
        r_a2[i] <= '0;
        r_w[i]  <= '0;
      end
      r_pend      <= '0;
      r_busy      <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_rej       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gnt       <= '0;
      r_rr        <= '0;
      r_done_cnt  <= '0;
      r_start_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a            <= r_a1[w_gnt];
            r_b            <= r_a2[w_gnt];
            r_gnt          <= w_gnt;
            r_pend[w_gnt]  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_fin) begin
            if (r_a < r_b) r_b <= r_b - r_a;
            else           r_a <= r_a - r_b;
          end
        end
        S_STORE: begin
          r_w[r_gnt]    <= (r_a == '0) ? r_b : r_a;
          r_done[r_gnt] <= 1'b1;
          r_busy[r_gnt] <= 1'b0;
          r_err[r_gnt]  <= (r_a == '0) && (r_b == '0);
          r_done_cnt    <= r_done_cnt + 32'd1;
          r_rr          <= (r_gnt == 3'(CHANNELS - 1))
                           ? 3'd0 : r_gnt + 3'd1;
        end
        default: ;
      endcase
      // S read clears reject; a reject in the same cycle wins
      if (srd && w_is_ch && (w_reg == 2'd3))
        r_rej[w_ch] <= 1'b0;
      if (w_rej) begin
        r_rej[w_ch] <= 1'b1;
      end else if (w_wr_op) begin
        if (w_reg[0]) begin
          r_a2[w_ch]   <= WIDTH'(sdata_in);
          r_pend[w_ch] <= 1'b1;
          r_busy[w_ch] <= 1'b1;
          r_done[w_ch] <= 1'b0;
          r_err[w_ch]  <= 1'b0;
          r_start_cnt  <= r_start_cnt + 32'd1;
        end else begin
          r_a1[w_ch] <= WIDTH'(sdata_in);
        end
      end
    end
  end

  // read data is captured before this edge's write lands
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
      r_sdata   <= '0;
      r_gpio    <= '0;
    end else begin
      r_rd_v <= srd;
      if (srd)        r_rd_data <= w_rdata;
      if (r_rd_v)     r_sdata   <= r_rd_data;
      if (gpio_latch) r_gpio    <= gpio_in;
    end
  end

  assign sdata_out      = r_sdata;
  assign gpio_out       = r_done_cnt;
  assign gpio_in_s_insp = r_gpio;

endmodule
